// File: rtl/alu_share_arbiter.sv
// Purpose : round-robin share of one external combinational ALU between two requesters.
// Latency : accept in cycle 0 -> response valid in cycle 2; at most one operation in flight.
// Backpressure: no new grant until the owner takes its response; result held stable meanwhile.
module alu_share_arbiter #(
    parameter int NB_BITS = 32,
    parameter int NB_OPE  = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    // requester 0
    input  logic               i_req0_valid,
    input  logic [NB_BITS-1:0] i_req0_a,
    input  logic [NB_BITS-1:0] i_req0_b,
    input  logic [NB_OPE-1:0]  i_req0_ope,
    output logic               o_req0_ready,
    // requester 1
    input  logic               i_req1_valid,
    input  logic [NB_BITS-1:0] i_req1_a,
    input  logic [NB_BITS-1:0] i_req1_b,
    input  logic [NB_OPE-1:0]  i_req1_ope,
    output logic               o_req1_ready,
    // shared ALU
    output logic [NB_BITS-1:0] o_alu_a,
    output logic [NB_BITS-1:0] o_alu_b,
    output logic [NB_OPE-1:0]  o_alu_ope,
    input  logic [NB_BITS-1:0] i_alu_result,
    input  logic               i_alu_zero,
    // responses
    output logic               o_rsp0_valid,
    output logic               o_rsp1_valid,
    input  logic               i_rsp0_ready,
    input  logic               i_rsp1_ready,
    output logic [NB_BITS-1:0] o_rsp_data,
    output logic               o_rsp_zero,
    output logic               o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // One operation as presented to the ALU.
    typedef struct packed {
        logic [NB_BITS-1:0] a;
        logic [NB_BITS-1:0] b;
        logic [NB_OPE-1:0]  ope;
    } op_t;

    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;       // 0: req0 has priority on a tie, 1: req1
    logic               owner_q, owner_d;   // requester whose op is in flight
    op_t                op_q, op_d;         // registered ALU inputs
    logic [NB_BITS-1:0] rsp_data_q, rsp_data_d;
    logic               rsp_zero_q, rsp_zero_d;

    op_t                req0_op;
    op_t                req1_op;
    logic               any_req;
    logic               win_sel;            // 0: req0 wins, 1: req1 wins
    logic               owner_rsp_rdy;
    logic               req0_ready_c;
    logic               req1_ready_c;

    assign req0_op = '{a: i_req0_a, b: i_req0_b, ope: i_req0_ope};
    assign req1_op = '{a: i_req1_a, b: i_req1_b, ope: i_req1_ope};

    // Winner selection: a lone requester always wins, the pointer only breaks ties.
    always_comb begin
        any_req = i_req0_valid | i_req1_valid;
        win_sel = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            win_sel = ptr_q;
        end else if (i_req1_valid) begin
            win_sel = 1'b1;
        end
        owner_rsp_rdy = owner_q ? i_rsp1_ready : i_rsp0_ready;
    end

    // Next-state and grant logic for the IDLE -> EXEC -> RESP cycle.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        op_d         = op_q;
        rsp_data_d   = rsp_data_q;
        rsp_zero_d   = rsp_zero_q;
        req0_ready_c = 1'b0;
        req1_ready_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    req0_ready_c = ~win_sel;
                    req1_ready_c = win_sel;
                    owner_d      = win_sel;
                    op_d         = win_sel ? req1_op : req0_op;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // ALU has had a full cycle on the registered operands.
                rsp_data_d = i_alu_result;
                rsp_zero_d = i_alu_zero;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                // Only the owner's ready completes the handshake; priority then
                // passes to the other requester.
                if (owner_rsp_rdy) begin
                    ptr_d   = ~owner_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer, ALU operand and result registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 1'b0;
            owner_q    <= 1'b0;
            op_q       <= '0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            op_q       <= op_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
        end
    end

    // Grants are combinational; masking with reset keeps them low while reset is held
    // even if a requester is already presenting valid.
    assign o_req0_ready = req0_ready_c & i_rst_n;
    assign o_req1_ready = req1_ready_c & i_rst_n;

    assign o_alu_a      = op_q.a;
    assign o_alu_b      = op_q.b;
    assign o_alu_ope    = op_q.ope;

    assign o_rsp0_valid = (state_q == ST_RESP) && !owner_q;
    assign o_rsp1_valid = (state_q == ST_RESP) &&  owner_q;
    assign o_rsp_data   = rsp_data_q;
    assign o_rsp_zero   = rsp_zero_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule
